// File: rtl/key_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// key_pkg : shared FSM encodings and defaults for the key filter.
// Rev 1.0
// ------------------------------------------------------------------
package key_pkg;

  // 20 ms of stable samples at 50 MHz
  localparam int CNT_MAX_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_FILT = 2'd1,
    ST_DOWN       = 2'd2,
    ST_REL_FILT   = 2'd3
  } key_state_e;

endpackage
`default_nettype wire

// File: rtl/key_filter_ch.sv
`default_nettype none
// ------------------------------------------------------------------
// key_filter_ch : synchroniser, debounce FSM and counter for one key.
// Optional: KEY_FILTER_TOGGLE_EN adds toggle_o. Rev 1.0
// ------------------------------------------------------------------
module key_filter_ch
  import key_pkg::*;
#(
  parameter int CNT_MAX        = CNT_MAX_DEFAULT,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
`ifdef KEY_FILTER_TOGGLE_EN
  ,
  output logic toggle_o
`endif
);

  localparam int            CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic          IDLE_PIN = KEY_ACTIVE_LOW;

  logic [1:0]    sync_q;
  logic          pressed;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Preset to the released pin level so reset exit never looks like a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {2{IDLE_PIN}};
    else      sync_q <= {sync_q[0], key_i};
  end

  assign pressed = sync_q[1] ^ IDLE_PIN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_FILT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_FILT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DOWN;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DOWN: begin
        if (!pressed) begin
          state_d = ST_REL_FILT;
          cnt_d   = '0;
        end
      end
      ST_REL_FILT: begin
        if (pressed) begin
          state_d = ST_DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_FILTER_TOGGLE_EN
  logic toggle_q;

  // Flips on the same edge that registers the press pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         toggle_q <= 1'b0;
    else if (press_d) toggle_q <= ~toggle_q;
  end

  assign toggle_o = toggle_q;
`endif

endmodule
`default_nettype wire

// File: rtl/key_filter.sv
`default_nettype none
// ------------------------------------------------------------------
// key_filter : N-channel push-button debouncer with press/release pulses.
// Optional: KEY_FILTER_TOGGLE_EN adds key_toggle. Rev 1.0
// ------------------------------------------------------------------
module key_filter
  import key_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int CNT_MAX        = CNT_MAX_DEFAULT,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
`ifdef KEY_FILTER_TOGGLE_EN
  ,
  output logic [N_KEYS-1:0] key_toggle
`endif
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .CNT_MAX        (CNT_MAX),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW != 0)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_i     (key_in[i]),
      .level_o   (key_level[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i])
`ifdef KEY_FILTER_TOGGLE_EN
      ,
      .toggle_o  (key_toggle[i])
`endif
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_filter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_key_filter : directed bench with an expected-pulse scoreboard.
// Rev 1.0
// ------------------------------------------------------------------
module tb_key_filter;

  localparam int NK  = 4;
  localparam int CM  = 8;
  localparam int LAT = CM + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level, key_press, key_release;
`ifdef KEY_FILTER_TOGGLE_EN
  logic [NK-1:0] key_toggle;
  logic [NK-1:0] tog_exp = '0;
`endif

  key_filter #(.N_KEYS(NK), .CNT_MAX(CM), .KEY_ACTIVE_LOW(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_FILTER_TOGGLE_EN
    ,
    .key_toggle  (key_toggle)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ch; bit rel; } ev_t;
  ev_t sb[$];
  int  cyc    = 0;
  int  total  = 0;
  int  bad    = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc++;

  // Pop every pulse due this cycle and compare the full pulse vectors
  always @(negedge clk) begin : mon
    logic [NK-1:0] ep, er;
    ep = '0;
    er = '0;
    if (mon_en) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          if (sb[i].rel) er[sb[i].ch] = 1'b1;
          else           ep[sb[i].ch] = 1'b1;
          sb.delete(i);
        end
      end
      total++;
      assert (key_press === ep) else begin
        bad++;
        $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, key_press, ep);
      end
      total++;
      assert (key_release === er) else begin
        bad++;
        $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, key_release, er);
      end
`ifdef KEY_FILTER_TOGGLE_EN
      if (!rst) tog_exp = '0;
      else      tog_exp = tog_exp ^ ep;
      total++;
      assert (key_toggle === tog_exp) else begin
        bad++;
        $error("FAIL toggle cyc=%0d observed=%b expected=%b", cyc, key_toggle, tog_exp);
      end
`endif
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stable change that the filter must accept: schedule its pulse
  task automatic set_key(input int ch, input bit pressed);
    ev_t e;
    key_in[ch] = ~pressed;
    e.cyc = cyc + LAT;
    e.ch  = ch;
    e.rel = ~pressed;
    sb.push_back(e);
  endtask

  task automatic chk_level(input logic [NK-1:0] e, input string tag);
    total++;
    assert (key_level === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, key_level, e);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk_level('0, "reset_level");
    total++;
    assert ({key_press, key_release} === '0) else begin
      bad++;
      $error("FAIL reset_pulses observed=%b expected=0", {key_press, key_release});
    end
    mon_en = 1'b1;
    wait_n(3);
    rst = 1'b1;
    wait_n(50);
    chk_level('0, "idle_50");

    // single press on key 0
    set_key(0, 1'b1);
    wait_n(LAT - 1);
    chk_level(4'b0000, "pre_press0");
    wait_n(4);
    chk_level(4'b0001, "held0");

    // bounce on key 1, then stable press and release
    for (int i = 0; i < 14; i++) begin
      key_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_n(3);
    end
    chk_level(4'b0001, "bounce1");
    set_key(1, 1'b1);
    wait_n(LAT + 4);
    chk_level(4'b0011, "held1");
    set_key(1, 1'b0);
    wait_n(LAT + 4);
    chk_level(4'b0001, "rel1");

    // key 2: short release is rejected, long release is accepted
    set_key(2, 1'b1);
    wait_n(LAT + 4);
    chk_level(4'b0101, "held2");
    key_in[2] = 1'b1;
    wait_n(5);
    key_in[2] = 1'b0;
    wait_n(LAT + 4);
    chk_level(4'b0101, "short_rel2");
    set_key(2, 1'b0);
    wait_n(LAT + 4);
    chk_level(4'b0001, "rel2");

    // keys 0 and 3 together
    set_key(0, 1'b0);
    wait_n(LAT + 4);
    chk_level(4'b0000, "rel0");
    set_key(0, 1'b1);
    set_key(3, 1'b1);
    wait_n(LAT + 4);
    chk_level(4'b1001, "held03");

    // asynchronous reset while in DOWN, keys still held
    #2 rst = 1'b0;
    #1;
    chk_level('0, "async_rst");
    wait_n(2);
    rst = 1'b1;
    set_key(0, 1'b1);
    set_key(3, 1'b1);
    wait_n(LAT - 1);
    chk_level(4'b0000, "requal_wait");
    wait_n(4);
    chk_level(4'b1001, "requal");

    // two more accepted presses on key 0
    set_key(0, 1'b0);
    wait_n(LAT + 4);
    set_key(0, 1'b1);
    wait_n(LAT + 4);
    set_key(0, 1'b0);
    wait_n(LAT + 4);
    set_key(0, 1'b1);
    wait_n(LAT + 4);
    chk_level(4'b1001, "final");

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
